// File: rtl/intersection_phase_scheduler_pkg.sv
// rtl/intersection_phase_scheduler_pkg.sv - shared phase encoding, default timing and green decode
package intersection_pkg;

  typedef enum logic [1:0] {
    PH_THROUGH = 2'd0,
    PH_TURN    = 2'd1,
    PH_PED     = 2'd2,
    PH_CLEAR   = 2'd3
  } phase_t;

  localparam int CNT_W          = 8;
  localparam int DEF_MIN_GREEN  = 4;
  localparam int DEF_PHASE_TIME = 4;
  localparam int DEF_CLEAR_TIME = 2;

  // Bit order {up, down, turn, ped}; CLEAR leaves every group dark.
  function automatic logic [3:0] green_decode(input phase_t ph);
    logic [3:0] g;
    case (ph)
      PH_THROUGH: g = 4'b1100;
      PH_TURN:    g = 4'b0010;
      PH_PED:     g = 4'b0001;
      default:    g = 4'b0000;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/intersection_phase_scheduler_phase_timer.sv
// rtl/intersection_phase_scheduler_phase_timer.sv - saturating per-phase cycle counter with expire flag
module phase_timer
  import intersection_pkg::*;
(
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_duration,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (r_count != {CNT_W{1'b1}}) begin
      r_count <= r_count + 1'b1;
    end
  end

  // >= rather than == so a saturated THROUGH counter keeps reporting expiry.
  assign o_expire = (r_count >= (i_duration - 1'b1));

endmodule

// File: rtl/intersection_phase_scheduler.sv
// rtl/intersection_phase_scheduler.sv - round-robin THROUGH/TURN/PED scheduler with all-red clearance
module intersection_phase_scheduler
  import intersection_pkg::*;
#(
  parameter int MIN_GREEN  = DEF_MIN_GREEN,
  parameter int PHASE_TIME = DEF_PHASE_TIME,
  parameter int CLEAR_TIME = DEF_CLEAR_TIME
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_pedestrian_button,
  input  logic       i_turn_sensor,
  output logic       o_up_green,
  output logic       o_down_green,
  output logic       o_turn_green,
  output logic       o_pedestrian_green,
  output logic [1:0] o_phase,
  output logic       o_ped_pending,
  output logic       o_turn_pending
);

  phase_t           r_phase;
  phase_t           r_next_target;
  logic [3:0]       r_greens;
  logic             r_ped_pending;
  logic             r_turn_pending;

  phase_t           w_next_phase;
  phase_t           w_next_target;
  logic [CNT_W-1:0] w_duration;
  logic             w_expire;
  logic             w_phase_change;
  logic             w_enter_ped;
  logic             w_enter_turn;

  always_comb begin
    case (r_phase)
      PH_THROUGH:     w_duration = CNT_W'(MIN_GREEN);
      PH_TURN, PH_PED: w_duration = CNT_W'(PHASE_TIME);
      default:        w_duration = CNT_W'(CLEAR_TIME);
    endcase
  end

  phase_timer u_timer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    (w_phase_change),
    .i_duration (w_duration),
    .o_expire   (w_expire)
  );

  // Every green exits through CLEAR; CLEAR then enters the target chosen on the way out.
  always_comb begin
    w_next_phase  = r_phase;
    w_next_target = r_next_target;
    case (r_phase)
      PH_THROUGH: begin
        if (w_expire && (r_ped_pending || r_turn_pending)) begin
          w_next_phase  = PH_CLEAR;
          w_next_target = r_turn_pending ? PH_TURN : PH_PED;
        end
      end
      PH_TURN: begin
        if (w_expire) begin
          w_next_phase  = PH_CLEAR;
          w_next_target = r_ped_pending ? PH_PED : PH_THROUGH;
        end
      end
      PH_PED: begin
        if (w_expire) begin
          w_next_phase  = PH_CLEAR;
          w_next_target = PH_THROUGH;
        end
      end
      default: begin
        if (w_expire) begin
          w_next_phase = r_next_target;
        end
      end
    endcase
  end

  assign w_phase_change = (w_next_phase != r_phase);
  assign w_enter_ped    = w_phase_change && (w_next_phase == PH_PED);
  assign w_enter_turn   = w_phase_change && (w_next_phase == PH_TURN);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_phase        <= PH_CLEAR;
      r_next_target  <= PH_THROUGH;
      r_greens       <= 4'b0000;
      r_ped_pending  <= 1'b0;
      r_turn_pending <= 1'b0;
    end else begin
      r_phase       <= w_next_phase;
      r_next_target <= w_next_target;
      r_greens      <= green_decode(w_next_phase);
      if (w_enter_ped) begin
        r_ped_pending <= 1'b0;
      end else if (i_pedestrian_button && (r_phase != PH_PED)) begin
        r_ped_pending <= 1'b1;
      end
      if (w_enter_turn) begin
        r_turn_pending <= 1'b0;
      end else if (i_turn_sensor && (r_phase != PH_TURN)) begin
        r_turn_pending <= 1'b1;
      end
    end
  end

  assign o_up_green         = r_greens[3];
  assign o_down_green       = r_greens[2];
  assign o_turn_green       = r_greens[1];
  assign o_pedestrian_green = r_greens[0];
  assign o_phase            = r_phase;
  assign o_ped_pending      = r_ped_pending;
  assign o_turn_pending     = r_turn_pending;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb/tb_intersection_phase_scheduler.sv - directed and random bench for the phase scheduler
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       turn = 1'b0;
  logic       up_g, down_g, turn_g, ped_g;
  logic [1:0] phase;
  logic       ped_p, turn_p;

  int         n_checks = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  int         cyc = 0;
  int         wait_start = 0;
  bit         wait_active = 1'b0;
  logic [1:0] prev_phase = 2'd3;
  logic [3:0] mon_exp_g;

  intersection_phase_scheduler #(
    .MIN_GREEN  (4),
    .PHASE_TIME (4),
    .CLEAR_TIME (2)
  ) dut (
    .i_clock             (clk),
    .i_reset             (rst),
    .i_pedestrian_button (btn),
    .i_turn_sensor       (turn),
    .o_up_green          (up_g),
    .o_down_green        (down_g),
    .o_turn_green        (turn_g),
    .o_pedestrian_green  (ped_g),
    .o_phase             (phase),
    .o_ped_pending       (ped_p),
    .o_turn_pending      (turn_p)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Per-cycle invariants and pedestrian wait bound, sampled on pre-edge values.
  always @(posedge clk) begin
    cyc++;
    if (mon_en) begin
      mon_exp_g = {phase == 2'd0, phase == 2'd0, phase == 2'd1, phase == 2'd2};
      n_checks++;
      if ({up_g, down_g, turn_g, ped_g} !== mon_exp_g) begin
        n_fail++;
        $display("FAIL green_decode: greens=%b expected %b phase=%0d", {up_g, down_g, turn_g, ped_g}, mon_exp_g, phase);
      end
      n_checks++;
      if (prev_phase != 2'd3 && phase != 2'd3 && phase != prev_phase) begin
        n_fail++;
        $display("FAIL no_clearance: phase %0d -> %0d, expected CLEAR (3) between", prev_phase, phase);
      end
      if (rst) begin
        wait_active = 1'b0;
      end else if (wait_active) begin
        if (ped_g) begin
          n_checks++;
          if (cyc - wait_start > 15) begin
            n_fail++;
            $display("FAIL ped_wait: waited %0d cycles, required <= 15", cyc - wait_start);
          end
          wait_active = 1'b0;
        end else if (cyc - wait_start > 15) begin
          n_checks++;
          n_fail++;
          $display("FAIL ped_wait: still waiting after %0d cycles, required <= 15", cyc - wait_start);
          wait_active = 1'b0;
        end
      end else if (btn && phase != 2'd2) begin
        wait_active = 1'b1;
        wait_start  = cyc;
      end
    end
    prev_phase = phase;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_phase(input logic [1:0] p, input string name);
    int n;
    n = 0;
    while (phase !== p && n < 50) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL %s: phase=%0d after %0d cycles, required %0d", name, phase, n, p);
    end
  endtask

  task automatic settle();
    int n;
    btn = 1'b0;
    turn = 1'b0;
    n = 0;
    while (!(phase === 2'd0 && ped_p === 1'b0 && turn_p === 1'b0) && n < 100) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL settle: phase=%0d ped_p=%b turn_p=%b, required idle THROUGH", phase, ped_p, turn_p);
    end
    repeat (6) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    step();
    n_checks++;
    if (phase !== 2'd3) begin n_fail++; $display("FAIL reset_phase: got %0d required 3", phase); end
    n_checks++;
    if ({up_g, down_g, turn_g, ped_g} !== 4'b0000) begin n_fail++; $display("FAIL reset_greens: got %b required 0000", {up_g, down_g, turn_g, ped_g}); end
    n_checks++;
    if ({ped_p, turn_p} !== 2'b00) begin n_fail++; $display("FAIL reset_pending: got %b required 00", {ped_p, turn_p}); end
    rst = 1'b0;
    mon_en = 1'b1;
    step();
    n_checks++;
    if (phase !== 2'd3) begin n_fail++; $display("FAIL reset_clear_cycle1: got %0d required 3", phase); end
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if ({phase, up_g, down_g, turn_g, ped_g} !== 6'b00_1100) begin
        n_fail++;
        $display("FAIL reset_through[%0d]: phase=%0d greens=%b required phase 0 greens 1100", i, phase, {up_g, down_g, turn_g, ped_g});
      end
    end
  endtask

  task automatic test_ped_single();
    int eph[10];
    int epp[10];
    eph = '{0, 3, 3, 2, 2, 2, 2, 3, 3, 0};
    epp = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    settle();
    btn = 1'b1;
    step();
    btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      n_checks++;
      if (phase !== 2'(eph[i])) begin n_fail++; $display("FAIL ped_single_phase[%0d]: got %0d required %0d", i, phase, eph[i]); end
      n_checks++;
      if (ped_p !== 1'(epp[i])) begin n_fail++; $display("FAIL ped_single_pending[%0d]: got %b required %0d", i, ped_p, epp[i]); end
    end
  endtask

  // Must run straight after test_ped_single: starts on the first THROUGH cycle.
  task automatic test_min_green();
    int eph[6];
    eph = '{0, 0, 0, 3, 3, 2};
    btn = 1'b1;
    step();
    btn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      n_checks++;
      if (phase !== 2'(eph[i])) begin n_fail++; $display("FAIL min_green_phase[%0d]: got %0d required %0d", i, phase, eph[i]); end
    end
  endtask

  task automatic test_turn_ped();
    int eph[16];
    settle();
    eph = '{0, 3, 3, 1, 1, 1, 1, 3, 3, 2, 2, 2, 2, 3, 3, 0};
    btn = 1'b1;
    turn = 1'b1;
    step();
    btn = 1'b0;
    turn = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      n_checks++;
      if (phase !== 2'(eph[i])) begin n_fail++; $display("FAIL turn_ped_phase[%0d]: got %0d required %0d", i, phase, eph[i]); end
      n_checks++;
      if (ped_p !== (i < 9)) begin n_fail++; $display("FAIL turn_ped_ped_pending[%0d]: got %b required %b", i, ped_p, (i < 9)); end
      n_checks++;
      if (turn_p !== (i < 3)) begin n_fail++; $display("FAIL turn_ped_turn_pending[%0d]: got %b required %b", i, turn_p, (i < 3)); end
    end
  endtask

  task automatic test_ped_bound();
    int cnt;
    bit saw_turn;
    settle();
    btn = 1'b1;
    step();
    btn = 1'b0;
    wait_phase(2'd2, "bound_reach_ped");
    wait_phase(2'd3, "bound_reach_clear");
    btn = 1'b1;
    turn = 1'b1;
    cnt = 0;
    saw_turn = 1'b0;
    do begin
      step();
      cnt++;
      btn = 1'b0;
      if (turn_g) saw_turn = 1'b1;
    end while (!ped_g && cnt < 40);
    n_checks++;
    if (cnt !== 14) begin n_fail++; $display("FAIL ped_bound_latency: got %0d cycles required 14", cnt); end
    n_checks++;
    if (saw_turn !== 1'b1) begin n_fail++; $display("FAIL ped_bound_turn_served: got %b required 1", saw_turn); end
    turn = 1'b0;
  endtask

  task automatic test_ped_during_green();
    settle();
    btn = 1'b1;
    step();
    btn = 1'b0;
    wait_phase(2'd2, "during_green_reach_ped");
    step();
    btn = 1'b1;
    step();
    n_checks++;
    if (ped_p !== 1'b0) begin n_fail++; $display("FAIL during_green_pending_a: got %b required 0", ped_p); end
    step();
    btn = 1'b0;
    n_checks++;
    if (ped_p !== 1'b0) begin n_fail++; $display("FAIL during_green_pending_b: got %b required 0", ped_p); end
    for (int i = 0; i < 24; i++) begin
      step();
      n_checks++;
      if (i >= 1 && phase === 2'd2) begin n_fail++; $display("FAIL during_green_repeat[%0d]: got phase 2 required no second PED", i); end
    end
  endtask

  task automatic test_reset_mid_turn();
    settle();
    btn = 1'b1;
    turn = 1'b1;
    step();
    btn = 1'b0;
    turn = 1'b0;
    wait_phase(2'd1, "mid_turn_reach_turn");
    step();
    n_checks++;
    if (ped_p !== 1'b1) begin n_fail++; $display("FAIL mid_turn_pre_pending: got %b required 1", ped_p); end
    rst = 1'b1;
    btn = 1'b1;
    turn = 1'b1;
    step();
    rst = 1'b0;
    btn = 1'b0;
    turn = 1'b0;
    n_checks++;
    if (phase !== 2'd3) begin n_fail++; $display("FAIL mid_turn_phase: got %0d required 3", phase); end
    n_checks++;
    if ({up_g, down_g, turn_g, ped_g} !== 4'b0000) begin n_fail++; $display("FAIL mid_turn_greens: got %b required 0000", {up_g, down_g, turn_g, ped_g}); end
    n_checks++;
    if ({ped_p, turn_p} !== 2'b00) begin n_fail++; $display("FAIL mid_turn_pending: got %b required 00", {ped_p, turn_p}); end
    step();
    n_checks++;
    if (phase !== 2'd3) begin n_fail++; $display("FAIL mid_turn_clear2: got %0d required 3", phase); end
    step();
    n_checks++;
    if ({phase, up_g, down_g} !== 4'b0011) begin n_fail++; $display("FAIL mid_turn_resume: phase=%0d up=%b down=%b required THROUGH", phase, up_g, down_g); end
  endtask

  task automatic test_random();
    int ped_entries;
    logic [1:0] last;
    settle();
    ped_entries = 0;
    last = phase;
    for (int i = 0; i < 10000; i++) begin
      btn  = ($urandom_range(0, 19) == 0);
      turn = ($urandom_range(0, 3) == 0);
      step();
      if (phase === 2'd2 && last !== 2'd2) ped_entries++;
      last = phase;
    end
    btn = 1'b0;
    turn = 1'b0;
    n_checks++;
    if (ped_entries == 0) begin n_fail++; $display("FAIL random_ped_served: got %0d PED phases required > 0", ped_entries); end
    repeat (20) step();
  endtask

  initial begin
    test_reset();
    test_ped_single();
    test_min_green();
    test_turn_ped();
    test_ped_bound();
    test_ped_during_green();
    test_reset_mid_turn();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
